// File: rtl/multi_servo_pkg.sv
// Shared defaults and helpers for the multi-channel servo PWM controller.
package multi_servo_pkg;

  localparam int DEF_CLK_DIV   = 50;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_TW        = 15;
  localparam int DEF_PW_MIN    = 1000;
  localparam int DEF_PW_MAX    = 2000;
  localparam int DEF_SLEW      = 20;

  function automatic int unsigned clamp(input int unsigned val,
                                        input int unsigned lo,
                                        input int unsigned hi);
    if (val < lo)      return lo;
    else if (val > hi) return hi;
    else               return val;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target, slew-limited shadow, frame-aligned active
// width and the registered PWM comparator.
module servo_channel
  import multi_servo_pkg::*;
#(
  parameter int TW     = DEF_TW,
  parameter int PW_MIN = DEF_PW_MIN,
  parameter int PW_MAX = DEF_PW_MAX,
  parameter int SLEW   = DEF_SLEW
) (
  input  logic          clk_50M,
  input  logic          reset,
  input  logic          i_move_en,
  input  logic          i_load,
  input  logic [TW-1:0] i_thresh,
  input  logic          i_step,
  input  logic          i_frame_load,
  input  logic [TW-1:0] i_us_count,
  output logic          o_pwm
);

  localparam logic [TW-1:0] PW_CTR = TW'((PW_MIN + PW_MAX) / 2);
  localparam logic [TW-1:0] SLEW_W = TW'(SLEW);

  logic [TW-1:0] r_target;
  logic [TW-1:0] r_shadow;
  logic [TW-1:0] r_active;
  logic          r_pwm;

  logic [TW-1:0] w_clamped;
  logic          w_up;
  logic [TW-1:0] w_diff;
  logic [TW-1:0] w_step_amt;
  logic [TW-1:0] w_shadow_next;

  assign w_clamped = TW'(clamp(32'(i_thresh), PW_MIN, PW_MAX));

  // Larger minus smaller keeps the distance unsigned without wrap.
  always_comb begin
    w_up          = (r_target > r_shadow);
    w_diff        = w_up ? (r_target - r_shadow) : (r_shadow - r_target);
    w_step_amt    = (w_diff > SLEW_W) ? SLEW_W : w_diff;
    w_shadow_next = w_up ? (r_shadow + w_step_amt) : (r_shadow - w_step_amt);
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_target <= PW_CTR;
      r_shadow <= PW_CTR;
      r_active <= PW_CTR;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load)       r_target <= w_clamped;
      if (i_step)       r_shadow <= w_shadow_next;
      if (i_frame_load) r_active <= r_shadow;
      r_pwm <= i_move_en && (i_us_count < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/multi_servo_ctrl.sv
// Multi-channel servo PWM controller: shared us timebase, vsync edge detect
// and NCH slew-limited channels updated only at frame boundaries.
module multi_servo_ctrl
  import multi_servo_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int TW        = DEF_TW,
  parameter int PW_MIN    = DEF_PW_MIN,
  parameter int PW_MAX    = DEF_PW_MAX,
  parameter int SLEW      = DEF_SLEW
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              move_en,
  input  logic              vsync_in,
  input  logic [NCH*TW-1:0] thresh_in,
  input  logic [NCH-1:0]    thresh_valid,
  output logic [NCH-1:0]    pwm_out,
  output logic              frame_start
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (NCH < 1 || NCH > 8 || PW_MIN > PW_MAX || PW_MAX >= PERIOD_US ||
      PERIOD_US >= (1 << TW)) begin : g_bad_params
    $error("multi_servo_ctrl: illegal parameter combination");
  end

  logic [DIVW-1:0] r_div;
  logic [TW-1:0]   r_us;
  logic            r_frame_start;
  logic            r_sync0;
  logic            r_sync1;
  logic            r_sync2;

  logic w_tick;
  logic w_wrap;
  logic w_vsync_rise;

  assign w_tick       = (r_div == DIVW'(CLK_DIV - 1));
  assign w_wrap       = w_tick && (r_us == TW'(PERIOD_US - 1));
  assign w_vsync_rise = r_sync1 && !r_sync2;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_div         <= '0;
      r_us          <= '0;
      r_frame_start <= 1'b0;
      r_sync0       <= 1'b0;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_us <= w_wrap ? '0 : r_us + 1'b1;
      r_frame_start <= w_wrap;
      r_sync0       <= vsync_in;
      r_sync1       <= r_sync0;
      r_sync2       <= r_sync1;
    end
  end

  assign frame_start = r_frame_start;

  // Active widths load on the same edge the counter wraps, so they are in place
  // for the whole frame_start cycle and the frame that follows.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    servo_channel #(
      .TW    (TW),
      .PW_MIN(PW_MIN),
      .PW_MAX(PW_MAX),
      .SLEW  (SLEW)
    ) u_ch (
      .clk_50M     (clk_50M),
      .reset       (reset),
      .i_move_en   (move_en),
      .i_load      (thresh_valid[gi]),
      .i_thresh    (thresh_in[gi*TW +: TW]),
      .i_step      (w_vsync_rise),
      .i_frame_load(w_wrap),
      .i_us_count  (r_us),
      .o_pwm       (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_multi_servo_ctrl.sv
// Directed bench for multi_servo_ctrl with small timing parameters
// (4 clocks per us, 100 us frame, so one frame is 400 clocks).
module tb_multi_servo_ctrl;

  localparam int NCH = 2;
  localparam int TW  = 15;

  logic              clk_50M = 1'b0;
  logic              reset   = 1'b1;
  logic              move_en = 1'b1;
  logic              vsync_in = 1'b0;
  logic [NCH*TW-1:0] thresh_in = '0;
  logic [NCH-1:0]    thresh_valid = '0;
  logic [NCH-1:0]    pwm_out;
  logic              frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  multi_servo_ctrl #(
    .NCH(NCH), .CLK_DIV(4), .PERIOD_US(100), .TW(TW),
    .PW_MIN(10), .PW_MAX(90), .SLEW(5)
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .move_en     (move_en),
    .vsync_in    (vsync_in),
    .thresh_in   (thresh_in),
    .thresh_valid(thresh_valid),
    .pwm_out     (pwm_out),
    .frame_start (frame_start)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Cycles until the next frame_start, bounded.
  task automatic count_fs(output int n);
    n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (!frame_start && n < 1000);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  task automatic wait_fs();
    int n;
    count_fs(n);
  endtask

  // Called on a frame_start cycle; counts high cycles until the next one.
  task automatic measure(output int h0, output int h1, output int len);
    h0  = int'(pwm_out[0]);
    h1  = int'(pwm_out[1]);
    len = 1;
    forever begin
      @(negedge clk_50M);
      if (frame_start || len >= 1000) break;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      len++;
    end
    if (!frame_start) chk("measure_timeout", 0, 1);
  endtask

  task automatic strobe(input logic [1:0] mask, input int v0, input int v1);
    logic [TW-1:0] t0;
    logic [TW-1:0] t1;
    t0 = TW'(v0);
    t1 = TW'(v1);
    thresh_in    = {t1, t0};
    thresh_valid = mask;
    @(negedge clk_50M);
    thresh_valid = '0;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    repeat (3) @(negedge clk_50M);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk_50M);
  endtask

  initial begin
    int h0, h1, len, n;

    // Reset state
    repeat (3) @(negedge clk_50M);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_fs", int'(frame_start), 0);

    // Defaults: 50 us pulses, 400-cycle frames
    reset = 1'b0;
    count_fs(n);
    chk("first_fs_latency", n, 400);
    measure(h0, h1, len);
    chk("dflt_ch0_hi", h0, 200);
    chk("dflt_ch1_hi", h1, 200);
    chk("dflt_frame_len", len, 400);

    // ch0 target 70: active steps by 5 per vsync, applied at the next frame
    strobe(2'b01, 70, 0);
    for (int k = 1; k <= 4; k++) begin
      vsync_pulse();
      wait_fs();
      measure(h0, h1, len);
      chk($sformatf("slew%0d_ch0_hi", k), h0, 4 * (50 + 5 * k));
      chk($sformatf("slew%0d_ch1_hi", k), h1, 200);
    end

    // Clamp limits: 5 -> 10, 200 -> 90 (several vsync steps within one frame)
    strobe(2'b11, 5, 200);
    repeat (14) vsync_pulse();
    wait_fs();
    measure(h0, h1, len);
    chk("clamp_lo_ch0_hi", h0, 40);
    chk("clamp_hi_ch1_hi", h1, 360);
    chk("clamp_frame_len", len, 400);

    // Zero request still yields the minimum width
    strobe(2'b01, 0, 0);
    repeat (2) vsync_pulse();
    wait_fs();
    measure(h0, h1, len);
    chk("zero_req_ch0_hi", h0, 40);

    // ch1 back to 50, then a strobe to 80 lands on the vsync step edge:
    // that step uses the old target (50 == shadow), later steps head to 80.
    strobe(2'b10, 0, 50);
    repeat (9) vsync_pulse();
    vsync_in = 1'b1;
    repeat (2) @(negedge clk_50M);
    thresh_in    = {TW'(80), TW'(0)};
    thresh_valid = 2'b10;
    @(negedge clk_50M);
    thresh_valid = '0;
    vsync_in     = 1'b0;
    repeat (3) @(negedge clk_50M);
    wait_fs();
    measure(h0, h1, len);
    chk("coinc_ch1_hi", h1, 200);
    vsync_pulse();
    wait_fs();
    measure(h0, h1, len);
    chk("coinc_next1_ch1_hi", h1, 220);
    vsync_pulse();
    wait_fs();
    measure(h0, h1, len);
    chk("coinc_next2_ch1_hi", h1, 240);

    // Reset at us 40 for 3 cycles aborts the frame
    repeat (160) @(negedge clk_50M);
    reset = 1'b1;
    repeat (3) @(negedge clk_50M);
    chk("midreset_pwm", int'(pwm_out), 0);
    chk("midreset_fs", int'(frame_start), 0);
    reset = 1'b0;
    count_fs(n);
    chk("midreset_fs_latency", n, 400);
    measure(h0, h1, len);
    chk("midreset_ch0_hi", h0, 200);
    chk("midreset_ch1_hi", h1, 200);

    // move_en low from us 30 to us 60 with active 50
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < 400; i++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (i == 121) chk("en_drop_pwm", int'(pwm_out), 0);
      if (i == 241) chk("en_reenable_pwm", int'(pwm_out), 0);
      if (i == 120) move_en = 1'b0;
      if (i == 240) move_en = 1'b1;
      @(negedge clk_50M);
    end
    chk("en_frame_ch0_hi", h0, 120);
    chk("en_frame_ch1_hi", h1, 120);
    chk("en_fs_unchanged", int'(frame_start), 1);
    measure(h0, h1, len);
    chk("en_next_ch0_hi", h0, 200);
    chk("en_next_ch1_hi", h1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, required 0");
    $fatal(1, "timeout");
  end

endmodule
